// File: rtl/dsp_48a1.sv
// DSP48A1-style slice: pre-adder, 18x18 multiplier, 48-bit post-adder.
// Every pipeline stage can be registered or bypassed by parameter.
module dsp_reg_stage #(
   parameter int W  = 18,
   parameter bit EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ce,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   generate
      if (EN) begin : g_reg
         logic [W-1:0] r;
         // Enabled register; reset clears it at once and wins over ce.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r <= '0;
            else if (ce)
               r <= d;
         end
         assign q = r;
      end else begin : g_byp
         logic unused_ctl;
         assign unused_ctl = &{1'b0, clk, rst_n, ce};
         assign q = d;
      end
   endgenerate
endmodule

module dsp_48a1 #(
   parameter int    WIDTH       = 18,
   parameter int    WIDTH_2     = 48,
   parameter bit    A0REG       = 1'b0,
   parameter bit    A1REG       = 1'b1,
   parameter bit    B0REG       = 1'b0,
   parameter bit    B1REG       = 1'b1,
   parameter bit    CREG        = 1'b1,
   parameter bit    DREG        = 1'b1,
   parameter bit    MREG        = 1'b1,
   parameter bit    PREG        = 1'b1,
   parameter bit    CARRYINREG  = 1'b1,
   parameter bit    CARRYOUTREG = 1'b1,
   parameter bit    OPMODEREG   = 1'b1,
   parameter string CARRYINSEL  = "OPMODE5",
   parameter string B_INPUT     = "DIRECT"
) (
   input  logic                 CLK,
   input  logic                 RSTA,
   input  logic                 RSTB,
   input  logic                 RSTC,
   input  logic                 RSTD,
   input  logic                 RSTCARRYIN,
   input  logic                 RSTM,
   input  logic                 RSTOPMODE,
   input  logic                 RSTP,
   input  logic                 CEA,
   input  logic                 CEB,
   input  logic                 CEC,
   input  logic                 CED,
   input  logic                 CECARRYIN,
   input  logic                 CEM,
   input  logic                 CEOPMODE,
   input  logic                 CEP,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic [WIDTH-1:0]     BCIN,
   input  logic [WIDTH-1:0]     D,
   input  logic [WIDTH_2-1:0]   C,
   input  logic [WIDTH_2-1:0]   PCIN,
   input  logic                 CARRYIN,
   input  logic [7:0]           OPMODE,
   output logic [2*WIDTH-1:0]   M,
   output logic [WIDTH_2-1:0]   P,
   output logic [WIDTH_2-1:0]   PCOUT,
   output logic [WIDTH-1:0]     BCOUT,
   output logic                 CARRYOUT,
   output logic                 CARRYOUTF
);
   localparam bit B_DIR  = (B_INPUT == "DIRECT");
   localparam bit B_CAS  = (B_INPUT == "CASCADE");
   localparam bit CI_OP5 = (CARRYINSEL == "OPMODE5");
   localparam bit CI_PIN = (CARRYINSEL == "CARRYIN");

   logic [WIDTH-1:0]   a0_q, a1_q, b_src, b0_q, pre, b1_q, d_q;
   logic [WIDTH_2-1:0] c_q, x_mux, z_mux, p_q;
   logic [7:0]         op;
   logic [2*WIDTH-1:0] mult, m_q;
   logic               ci_src, cin, cy_q;
   logic [WIDTH_2:0]   sum;

   dsp_reg_stage #(.W(WIDTH), .EN(A0REG)) u_a0 (
      .clk(CLK), .rst_n(RSTA), .ce(CEA), .d(A), .q(a0_q));
   dsp_reg_stage #(.W(WIDTH), .EN(A1REG)) u_a1 (
      .clk(CLK), .rst_n(RSTA), .ce(CEA), .d(a0_q), .q(a1_q));

   assign b_src = B_DIR ? B : (B_CAS ? BCIN : '0);

   dsp_reg_stage #(.W(WIDTH), .EN(B0REG)) u_b0 (
      .clk(CLK), .rst_n(RSTB), .ce(CEB), .d(b_src), .q(b0_q));
   dsp_reg_stage #(.W(WIDTH), .EN(DREG)) u_d (
      .clk(CLK), .rst_n(RSTD), .ce(CED), .d(D), .q(d_q));
   dsp_reg_stage #(.W(WIDTH_2), .EN(CREG)) u_c (
      .clk(CLK), .rst_n(RSTC), .ce(CEC), .d(C), .q(c_q));
   dsp_reg_stage #(.W(8), .EN(OPMODEREG)) u_op (
      .clk(CLK), .rst_n(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(op));

   // Pre-adder: D-B or D+B when enabled, else B0 passes through.
   always_comb begin
      pre = b0_q;
      if (op[4])
         pre = op[6] ? (d_q - b0_q) : (d_q + b0_q);
   end

   dsp_reg_stage #(.W(WIDTH), .EN(B1REG)) u_b1 (
      .clk(CLK), .rst_n(RSTB), .ce(CEB), .d(pre), .q(b1_q));

   assign mult = (2*WIDTH)'(b1_q) * (2*WIDTH)'(a1_q);

   dsp_reg_stage #(.W(2*WIDTH), .EN(MREG)) u_m (
      .clk(CLK), .rst_n(RSTM), .ce(CEM), .d(mult), .q(m_q));

   // X operand select.
   always_comb begin
      x_mux = '0;
      case (op[1:0])
         2'd1:    x_mux = WIDTH_2'(m_q);
         2'd2:    x_mux = p_q;
         2'd3:    x_mux = WIDTH_2'({d_q[11:0], a1_q, b1_q});
         default: x_mux = '0;
      endcase
   end

   // Z operand select.
   always_comb begin
      z_mux = '0;
      case (op[3:2])
         2'd1:    z_mux = PCIN;
         2'd2:    z_mux = p_q;
         2'd3:    z_mux = c_q;
         default: z_mux = '0;
      endcase
   end

   assign ci_src = CI_OP5 ? op[5] : (CI_PIN ? CARRYIN : 1'b0);

   dsp_reg_stage #(.W(1), .EN(CARRYINREG)) u_cyi (
      .clk(CLK), .rst_n(RSTCARRYIN), .ce(CECARRYIN),
      .d(ci_src), .q(cin));

   // Post-adder; the extra top bit is carry (add) or borrow (subtract).
   always_comb begin
      if (op[7])
         sum = {1'b0, z_mux}
             - ({1'b0, x_mux} + (WIDTH_2+1)'(cin));
      else
         sum = {1'b0, z_mux} + {1'b0, x_mux}
             + (WIDTH_2+1)'(cin);
   end

   dsp_reg_stage #(.W(WIDTH_2), .EN(PREG)) u_p (
      .clk(CLK), .rst_n(RSTP), .ce(CEP),
      .d(sum[WIDTH_2-1:0]), .q(p_q));
   dsp_reg_stage #(.W(1), .EN(CARRYOUTREG)) u_cyo (
      .clk(CLK), .rst_n(RSTP), .ce(CEP),
      .d(sum[WIDTH_2]), .q(cy_q));

   assign M         = m_q;
   assign P         = p_q;
   assign PCOUT     = p_q;
   assign BCOUT     = b1_q;
   assign CARRYOUT  = cy_q;
   assign CARRYOUTF = cy_q;
endmodule

// File: tb/tb_dsp_48a1.sv
// Bench for dsp_48a1: directed table, reset/CE corners,
// randomized settled-output checks and a P accumulation run.
module tb_dsp_48a1;
   logic        CLK = 1'b0;
   logic        RSTA, RSTB, RSTC, RSTD, RSTCARRYIN, RSTM, RSTOPMODE, RSTP;
   logic        CEA, CEB, CEC, CED, CECARRYIN, CEM, CEOPMODE, CEP;
   logic [17:0] A, B, BCIN, D;
   logic [47:0] C, PCIN;
   logic        CARRYIN;
   logic [7:0]  OPMODE;
   logic [35:0] M;
   logic [47:0] P, PCOUT;
   logic [17:0] BCOUT;
   logic        CARRYOUT, CARRYOUTF;

   always #5 CLK = ~CLK;

   dsp_48a1 dut (
      .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD),
      .RSTCARRYIN(RSTCARRYIN), .RSTM(RSTM), .RSTOPMODE(RSTOPMODE),
      .RSTP(RSTP), .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED),
      .CECARRYIN(CECARRYIN), .CEM(CEM), .CEOPMODE(CEOPMODE), .CEP(CEP),
      .A(A), .B(B), .BCIN(BCIN), .D(D), .C(C), .PCIN(PCIN),
      .CARRYIN(CARRYIN), .OPMODE(OPMODE), .M(M), .P(P), .PCOUT(PCOUT),
      .BCOUT(BCOUT), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF));

   typedef struct {
      logic [7:0]  op;
      logic [17:0] a, b, d;
      logic [47:0] c, pcin;
      int          clks;
      logic [17:0] bc;
      logic [35:0] m;
      logic [47:0] p;
      logic        cy;
   } vec_t;

   typedef struct {
      logic [17:0] bc;
      logic [35:0] m;
      logic [47:0] p;
      logic        cy;
   } res_t;

   localparam logic [63:0] MASK48 = 64'h0000_FFFF_FFFF_FFFF;

   int   n_vec = 0;
   int   n_bad = 0;
   vec_t tbl[4];
   res_t r;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input res_t e);
      chk({tag, " BCOUT"}, 64'(BCOUT), 64'(e.bc));
      chk({tag, " M"}, 64'(M), 64'(e.m));
      chk({tag, " P"}, 64'(P), 64'(e.p));
      chk({tag, " PCOUT"}, 64'(PCOUT), 64'(e.p));
      chk({tag, " CARRYOUT"}, 64'(CARRYOUT), 64'(e.cy));
      chk({tag, " CARRYOUTF"}, 64'(CARRYOUTF), 64'(e.cy));
   endtask

   task automatic set_rst(input logic v);
      RSTA = v; RSTB = v; RSTC = v; RSTD = v;
      RSTCARRYIN = v; RSTM = v; RSTOPMODE = v; RSTP = v;
   endtask

   task automatic set_ce(input logic [7:0] v);
      {CEA, CEB, CEC, CED, CECARRYIN, CEM, CEOPMODE, CEP} = v;
   endtask

   // Settled outputs for inputs held constant, with X/Z not fed from P.
   function automatic res_t ref_steady(
      input logic [7:0] op, input logic [17:0] a, b, d,
      input logic [47:0] c, pcin);
      res_t        o;
      logic [63:0] bb, x, z, ci, need, s;
      if (!op[4])    bb = 64'(b);
      else if (op[6]) bb = (64'(d) - 64'(b)) & 64'h3FFFF;
      else           bb = (64'(d) + 64'(b)) & 64'h3FFFF;
      o.bc = bb[17:0];
      o.m  = 36'(bb * 64'(a));
      case (op[1:0])
         2'd1:    x = 64'(o.m);
         2'd3:    x = (64'(d[11:0]) << 36) | (64'(a) << 18) | bb;
         default: x = 0;
      endcase
      case (op[3:2])
         2'd1:    z = 64'(pcin);
         2'd3:    z = 64'(c);
         default: z = 0;
      endcase
      ci = 64'(op[5]);
      if (op[7]) begin
         need = x + ci;
         o.cy = (need > z);
         o.p  = 48'((z - need) & MASK48);
      end else begin
         s    = z + x + ci;
         o.cy = s[48];
         o.p  = 48'(s & MASK48);
      end
      return o;
   endfunction

   initial begin
      int   n;
      logic [63:0] acc, s;
      res_t e;

      tbl[0] = '{8'b11011101, 18'd20, 18'd10, 18'd25, 48'd350, 48'd0,
                 4, 18'hF, 36'h12C, 48'h32, 1'b0};
      tbl[1] = '{8'b00010000, 18'd20, 18'd10, 18'd25, 48'd350, 48'd0,
                 3, 18'h23, 36'h2BC, 48'h0, 1'b0};
      tbl[2] = '{8'b00001010, 18'd20, 18'd10, 18'd25, 48'd350, 48'd0,
                 3, 18'hA, 36'hC8, 48'h0, 1'b0};
      tbl[3] = '{8'b10100111, 18'd5, 18'd6, 18'd25, 48'd350, 48'd3000,
                 3, 18'h6, 36'h1E, 48'hFE6F_FFEC_0BB1, 1'b1};

      // All resets low with random data and enables.
      set_rst(1'b0);
      set_ce(8'($urandom));
      A = 18'($urandom); B = 18'($urandom); BCIN = 18'($urandom);
      D = 18'($urandom); C = 48'({$urandom, $urandom});
      PCIN = 48'({$urandom, $urandom}); CARRYIN = 1'($urandom);
      OPMODE = 8'($urandom);
      @(negedge CLK);
      e = '{18'd0, 36'd0, 48'd0, 1'b0};
      chk_all("reset", e);

      set_rst(1'b1);
      set_ce(8'hFF);
      PCIN = 48'd0;
      CARRYIN = 1'b0;

      // Directed vectors.
      for (int i = 0; i < 4; i++) begin
         OPMODE = tbl[i].op; A = tbl[i].a; B = tbl[i].b;
         D = tbl[i].d; C = tbl[i].c; PCIN = tbl[i].pcin;
         repeat (tbl[i].clks) @(posedge CLK);
         #1;
         e = '{tbl[i].bc, tbl[i].m, tbl[i].p, tbl[i].cy};
         chk_all($sformatf("vec%0d", i), e);
      end

      // P holds with CEP low even though its input changes.
      CEP = 1'b0;
      PCIN = 48'd0;
      repeat (4) @(posedge CLK);
      #1;
      chk("cep hold P", 64'(P), 64'h0000_FE6F_FFEC_0BB1);
      chk("cep hold CY", 64'(CARRYOUT), 64'd1);

      // RSTP low mid-cycle clears P before any edge.
      @(negedge CLK);
      #2 RSTP = 1'b0;
      #1;
      chk("rstp async P", 64'(P), 64'd0);
      chk("rstp async CY", 64'(CARRYOUT), 64'd0);
      RSTP = 1'b1;
      #1;
      chk("rstp release P", 64'(P), 64'd0);
      @(posedge CLK);
      #1;
      chk("rstp noce P", 64'(P), 64'd0);
      CEP = 1'b1;
      @(posedge CLK);
      #1;
      e = ref_steady(OPMODE, A, B, D, C, PCIN);
      chk("rstp reload P", 64'(P), 64'(e.p));
      chk("rstp reload CY", 64'(CARRYOUT), 64'(e.cy));

      // Random settled-state vectors.
      for (int i = 0; i < 24; i++) begin
         OPMODE = 8'($urandom);
         if (OPMODE[1:0] == 2'd2) OPMODE[1:0] = 2'd3;
         if (OPMODE[3:2] == 2'd2) OPMODE[3:2] = 2'd3;
         A = 18'($urandom); B = 18'($urandom); D = 18'($urandom);
         BCIN = 18'($urandom); CARRYIN = 1'($urandom);
         C = 48'({$urandom, $urandom});
         PCIN = 48'({$urandom, $urandom});
         repeat (5) @(posedge CLK);
         #1;
         e = ref_steady(OPMODE, A, B, D, C, PCIN);
         chk_all($sformatf("rnd%0d op=%b", i, OPMODE), e);
      end

      // Accumulate M into P from a cleared P.
      OPMODE = 8'b00001001;
      A = 18'($urandom); B = 18'($urandom);
      RSTP = 1'b0;
      repeat (5) @(posedge CLK);
      #1 RSTP = 1'b1;
      n = 7;
      repeat (n) @(posedge CLK);
      #1;
      acc = 0;
      s = 0;
      for (int k = 0; k < n; k++) begin
         s   = acc + 64'(A) * 64'(B);
         acc = s & MASK48;
      end
      chk("acc P", 64'(P), acc);
      chk("acc CY", 64'(CARRYOUT), 64'(s[48]));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
